// File: rtl/vball_sound_latch_if.sv
// Sound-latch bus between the main CPU (master) and the latch block (slave).
// The sound-CPU read side travels on the same bundle.
interface vball_sound_latch_if;
   logic       m_we;
   logic [7:0] m_din;
   logic       m_clr;
   logic [7:0] m_status;
   logic       s_rd;
   logic [7:0] s_dout;
   logic       s_irq;

   modport master (
      output m_we, m_din, m_clr, s_rd,
      input  m_status, s_dout, s_irq
   );

   modport slave (
      input  m_we, m_din, m_clr, s_rd,
      output m_status, s_dout, s_irq
   );
endinterface

// File: rtl/vball_sound_latch.sv
// Main-to-sound CPU command latch: small FIFO with sticky overrun/underrun flags
// and a level interrupt that is held off for a fixed time after each read.
module vball_sound_latch #(
   parameter int DEPTH   = 4,
   parameter int HOLDOFF = 8
) (
   input logic               clk_sys,
   input logic               reset,
   vball_sound_latch_if.slave bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ZERO_C  = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE_C   = CW'(1'b1);
   localparam logic [AW-1:0] PTR_ONE_C   = AW'(1'b1);
   localparam logic [HW-1:0] HOLD_LOAD_C = HW'(HOLDOFF - 1);
   localparam logic [HW-1:0] HOLD_ZERO_C = {HW{1'b0}};
   localparam logic [HW-1:0] HOLD_ONE_C  = HW'(1'b1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ASSERT = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          ovr_r;
   logic          udr_r;
   logic [7:0]    dout_r;
   logic [1:0]    state_r;
   logic [HW-1:0] hcnt_r;
   logic          irq_r;

   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;
   logic          ovr_set_s;
   logic          udr_set_s;
   logic [CW-1:0] count_nxt_s;
   logic [1:0]    state_nxt_s;
   logic [HW-1:0] hcnt_nxt_s;
   logic          irq_nxt_s;

   // FIFO push/pop decisions; a read on a full FIFO frees the slot a same-cycle write uses.
   always_comb begin
      full_s    = (count_r == DEPTH_C);
      empty_s   = (count_r == CNT_ZERO_C);
      push_s    = bus.m_we && !bus.m_clr && (!full_s || bus.s_rd);
      pop_s     = bus.s_rd && !bus.m_clr && !empty_s;
      ovr_set_s = bus.m_we && !bus.m_clr && full_s && !bus.s_rd;
      udr_set_s = bus.s_rd && !bus.m_clr && empty_s;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE_C;
         2'b01:   count_nxt_s = count_r - CNT_ONE_C;
         default: count_nxt_s = count_r;
      endcase
   end

   // Interrupt FSM next state and holdoff counter.
   always_comb begin
      state_nxt_s = state_r;
      hcnt_nxt_s  = hcnt_r;
      if (bus.m_clr) begin
         state_nxt_s = ST_IDLE;
         hcnt_nxt_s  = HOLD_ZERO_C;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!empty_s) begin
                  state_nxt_s = ST_ASSERT;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_ASSERT: begin
               if (bus.s_rd) begin
                  state_nxt_s = ST_HOLD;
                  hcnt_nxt_s  = HOLD_LOAD_C;
               end else begin
                  state_nxt_s = ST_ASSERT;
               end
            end
            ST_HOLD: begin
               if (hcnt_r == HOLD_ZERO_C) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  hcnt_nxt_s = hcnt_r - HOLD_ONE_C;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               hcnt_nxt_s  = HOLD_ZERO_C;
            end
         endcase
      end
      irq_nxt_s = (state_nxt_s == ST_ASSERT);
   end

   // Latch storage; stale entries are harmless because the pointers define validity.
   always_ff @(posedge clk_sys) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= bus.m_din;
      end
   end

   // FIFO pointers, occupancy and sticky error flags.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= CNT_ZERO_C;
         ovr_r    <= 1'b0;
         udr_r    <= 1'b0;
      end else if (bus.m_clr) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= CNT_ZERO_C;
         ovr_r    <= 1'b0;
         udr_r    <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
         end
         count_r <= count_nxt_s;
         ovr_r   <= ovr_r | ovr_set_s;
         udr_r   <= udr_r | udr_set_s;
      end
   end

   // Sound-side data register: only a successful pop changes it; flush leaves it alone.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         dout_r <= 8'h00;
      end else if (pop_s) begin
         dout_r <= mem_r[rd_ptr_r];
      end
   end

   // Interrupt FSM state, holdoff counter and registered interrupt output.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         hcnt_r  <= HOLD_ZERO_C;
         irq_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         hcnt_r  <= hcnt_nxt_s;
         irq_r   <= irq_nxt_s;
      end
   end

   assign bus.m_status = {full_s, empty_s, ovr_r, udr_r, 4'(count_r)};
   assign bus.s_dout   = dout_r;
   assign bus.s_irq    = irq_r;

endmodule

// Status consistency checks for the sound latch, kept apart from the design.
module vball_sound_latch_chk (
   input logic       clk_sys,
   input logic       reset,
   input logic [7:0] m_status,
   input logic       s_irq
);

   a_full_empty_exclusive: assert property (
      @(posedge clk_sys) disable iff (reset) !(m_status[7] && m_status[6])
   );

   a_irq_known: assert property (
      @(posedge clk_sys) disable iff (reset) !$isunknown(s_irq)
   );

endmodule

// File: tb/tb_vball_sound_latch.sv
// Directed bench for vball_sound_latch (DEPTH=4, HOLDOFF=8): vector table plus
// hand sequences for interrupt holdoff timing and mid-cycle asynchronous reset.
module tb_vball_sound_latch;

   logic clk_sys;
   logic reset;
   int   n_cmp;
   int   n_err;

   vball_sound_latch_if bus();

   vball_sound_latch #(.DEPTH(4), .HOLDOFF(8)) u_dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   vball_sound_latch_chk u_chk (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .m_status (bus.m_status),
      .s_irq    (bus.s_irq)
   );

   typedef struct packed {
      logic       we;
      logic [7:0] din;
      logic       clr;
      logic       rd;
      logic [7:0] st;
      logic [7:0] dout;
      logic       irq;
   } vec_t;

   vec_t vecs [19];

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h, expected %02h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [7:0] din, input logic clr, input logic rd);
      bus.m_we  = we;
      bus.m_din = din;
      bus.m_clr = clr;
      bus.s_rd  = rd;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b0);

      //             we    din    clr   rd    status dout   irq
      vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 8'h00, 1'b0};
      vecs[1]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0};
      vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00, 1'b1};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h40, 8'h5A, 1'b0};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h50, 8'h5A, 1'b0};
      vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h40, 8'h5A, 1'b0};
      vecs[6]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h01, 8'h5A, 1'b0};
      vecs[7]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h02, 8'h5A, 1'b1};
      vecs[8]  = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h03, 8'h5A, 1'b1};
      vecs[9]  = '{1'b1, 8'h04, 1'b0, 1'b0, 8'h84, 8'h5A, 1'b1};
      vecs[10] = '{1'b1, 8'h05, 1'b0, 1'b0, 8'hA4, 8'h5A, 1'b1};
      vecs[11] = '{1'b1, 8'hAA, 1'b0, 1'b1, 8'hA4, 8'h01, 1'b0};
      vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h23, 8'h02, 1'b0};
      vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 8'h03, 1'b0};
      vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h21, 8'h04, 1'b0};
      vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h60, 8'hAA, 1'b0};
      vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h70, 8'hAA, 1'b0};
      vecs[17] = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h31, 8'hAA, 1'b0};
      vecs[18] = '{1'b1, 8'h77, 1'b1, 1'b1, 8'h40, 8'hAA, 1'b0};

      repeat (3) @(posedge clk_sys);
      #1;
      check("reset_status", bus.m_status, 8'h40);
      check("reset_dout", bus.s_dout, 8'h00);
      check("reset_irq", {7'd0, bus.s_irq}, 8'h00);
      reset = 1'b0;

      for (int i = 0; i < 19; i++) begin
         drive(vecs[i].we, vecs[i].din, vecs[i].clr, vecs[i].rd);
         step();
         check($sformatf("v%0d_status", i), bus.m_status, vecs[i].st);
         check($sformatf("v%0d_dout", i), bus.s_dout, vecs[i].dout);
         check($sformatf("v%0d_irq", i), {7'd0, bus.s_irq}, {7'd0, vecs[i].irq});
      end

      // Interrupt holdoff: two entries queued, one read, then 8 low cycles.
      drive(1'b1, 8'hB1, 1'b0, 1'b0);
      step();
      drive(1'b1, 8'hB2, 1'b0, 1'b0);
      step();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("hold_pre_status", bus.m_status, 8'h02);
      check("hold_pre_irq", {7'd0, bus.s_irq}, 8'h01);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      step();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("hold_dout", bus.s_dout, 8'hB1);
      check("hold_low_1", {7'd0, bus.s_irq}, 8'h00);
      for (int k = 2; k <= 8; k++) begin
         step();
         check($sformatf("hold_low_%0d", k), {7'd0, bus.s_irq}, 8'h00);
      end
      step();
      step();
      check("hold_rehigh_irq", {7'd0, bus.s_irq}, 8'h01);
      check("hold_rehigh_status", bus.m_status, 8'h01);

      // Asynchronous reset between clock edges with three entries queued.
      drive(1'b1, 8'hC1, 1'b0, 1'b0);
      step();
      drive(1'b1, 8'hC2, 1'b0, 1'b0);
      step();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("arst_pre_status", bus.m_status, 8'h03);
      check("arst_pre_irq", {7'd0, bus.s_irq}, 8'h01);
      #1 reset = 1'b1;
      #1;
      check("arst_status", bus.m_status, 8'h40);
      check("arst_irq", {7'd0, bus.s_irq}, 8'h00);
      check("arst_dout", bus.s_dout, 8'h00);
      #1 reset = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      step();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("arst_rd_status", bus.m_status, 8'h50);
      check("arst_rd_dout", bus.s_dout, 8'h00);
      check("arst_rd_irq", {7'd0, bus.s_irq}, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
